binary_mac_stream: RTL and testbench
====================================

Name: binary_mac_stream

Overview:
- Sequential successor to the 64-input combinational binary-weight MAC.
- Accepts an input/weight vector of arbitrary length as a stream of CHUNK-bit beats.
- Per beat, computes signed popcount(x&w&m) − popcount(x&~w&m) and accumulates it over a frame; mask m gives ternary weights (m=0 means weight 0).
- Emits one signed result per frame over a valid/ready handshake to the LIF membrane-update stage.

Parameters:
- CHUNK, 8, bits per input beat (≥1).
- MAX_CHUNKS, 8, maximum beats per frame (≥1); frame length limit = CHUNK*MAX_CHUNKS inputs.
- Derived localparam ACC_W = $clog2(CHUNK*MAX_CHUNKS)+2, signed accumulator/result width (8 at defaults).
- Derived localparam CNT_W = $clog2(MAX_CHUNKS+1), beat counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  beat valid.
- in_ready  out  1  block can accept a beat.
- in_x  in  CHUNK  input spikes for this beat.
- in_w  in  CHUNK  weight sign bits: 1 = +1, 0 = −1.
- in_m  in  CHUNK  weight enable: 0 forces the weight to 0; tie high for pure binary mode.
- in_last  in  1  final beat of the frame.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_y  out  ACC_W  signed frame sum (two's complement).
- out_beats  out  CNT_W  number of beats accumulated in the frame.
- out_err  out  1  frame was truncated at MAX_CHUNKS without in_last.

Behaviour:
- Reset (async, active-high):
  - state=IDLE, acc=0, beat count=0.
  - out_valid=0, out_y=0, out_beats=0, out_err=0.
  - in_ready=1 from the first clock after reset deassertion.
- States: IDLE (no beat yet), ACCUM (frame in progress), HOLD (result waiting).
- Beat accept = in_valid & in_ready. in_ready = 1 in IDLE/ACCUM, 0 in HOLD.
- Per accepted beat:
  - d = popcount(in_x&in_w&in_m) − popcount(in_x&~in_w&in_m), range −CHUNK..+CHUNK.
  - acc_next = acc + d; count_next = count + 1.
- IDLE → ACCUM on an accepted beat with in_last=0.
- IDLE → HOLD on an accepted beat with in_last=1 (single-beat frame).
- ACCUM → HOLD when the accepted beat has in_last=1, or when count_next == MAX_CHUNKS.
- On the transition into HOLD, register: out_y=acc_next, out_beats=count_next, out_err=(count_next==MAX_CHUNKS & !in_last). Then clear acc and count to 0.
- out_valid=1 in HOLD; result appears the cycle after the last beat is accepted (latency 1).
- In HOLD, out_valid & out_ready → IDLE the next cycle.
  - out_y, out_beats and out_err hold their values until the next result is loaded.
  - Bubble of one cycle: in_ready returns to 1 in IDLE.
- out_y, out_beats and out_err stay stable while out_valid=1 & out_ready=0.
- Beats after a truncation (err) are treated as the start of a new frame; there is no resynchronisation to in_last.
- No overflow is possible: |acc| ≤ CHUNK*MAX_CHUNKS < 2^(ACC_W−1). Width is guaranteed by ACC_W; there is no saturation logic.
- in_valid=0 in ACCUM: state and acc hold, with no timeout.
- Reset asserted mid-frame or in HOLD: the partial accumulation and the pending result are discarded and all outputs return to reset values immediately.
- Ignore in_x, in_w, in_m and in_last when in_valid=0.

Test Plan:
- Single beat, defaults: x=0xFF, w=0xFF, m=0xFF, last=1 → 1 cycle later out_valid=1, out_y=+8, out_beats=1, out_err=0.
- 8-beat frame (64 inputs), x=all ones, w=0x0F each beat, m=0xFF, last on beat 8 → out_y=0, out_beats=8. Then w=0x00 all beats → out_y=−64 (0xC0).
- Ternary mask: x=0xFF, w=0xFF, m=0x0F, last=1 → out_y=+4. Then m=0x00 → out_y=0.
- Truncation: 9 beats of x=w=m=0xFF, last never set → result after beat 8: out_y=+64, out_beats=8, out_err=1. Beat 9 starts a new frame; with last=1 on beat 9 → out_y=+8, out_err=0.
- Backpressure: hold out_ready=0 for 5 cycles after result → in_ready=0, out_* stable, extra in_valid beats not accepted. Raise out_ready → out_valid drops next cycle, in_ready=1.
- Reset mid-frame: after 3 beats of +8, assert reset asynchronously (not on a clock edge) → outputs zero immediately. After release, a 1-beat frame x=0xFF, w=0x00, m=0xFF → out_y=−8, out_beats=1.

Source files
------------

// File: rtl/binary_mac_stream_if.sv
// Stream bundle for the binary/ternary-weight MAC: beat input channel and
// frame-result output channel, each with its own valid/ready handshake.
interface binary_mac_stream_if #(
   parameter int CHUNK      = 8,
   parameter int MAX_CHUNKS = 8
);
   localparam int ACC_W = $clog2(CHUNK*MAX_CHUNKS) + 2;
   localparam int CNT_W = $clog2(MAX_CHUNKS + 1);

   logic             in_valid;
   logic             in_ready;
   logic [CHUNK-1:0] in_x;
   logic [CHUNK-1:0] in_w;
   logic [CHUNK-1:0] in_m;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_y;
   logic [CNT_W-1:0] out_beats;
   logic             out_err;

   // Producer of beats / consumer of results
   modport master (
      output in_valid, in_x, in_w, in_m, in_last, out_ready,
      input  in_ready, out_valid, out_y, out_beats, out_err
   );

   // The MAC itself
   modport slave (
      input  in_valid, in_x, in_w, in_m, in_last, out_ready,
      output in_ready, out_valid, out_y, out_beats, out_err
   );
endinterface

// File: rtl/binary_mac_stream.sv
// Streaming binary/ternary-weight MAC. Each CHUNK-bit beat contributes
// popcount(x&w&m) - popcount(x&~w&m) to a signed frame accumulator; one
// result per frame is offered on the output handshake.
module binary_mac_stream #(
   parameter int CHUNK      = 8,
   parameter int MAX_CHUNKS = 8
) (
   input  logic                clk,
   input  logic                reset,
   binary_mac_stream_if.slave  bus
);
   localparam int ACC_W = $clog2(CHUNK*MAX_CHUNKS) + 2;
   localparam int CNT_W = $clog2(MAX_CHUNKS + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CHUNKS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCUM,
      S_HOLD
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nx;
   logic signed [ACC_W-1:0] r_acc;
   logic signed [ACC_W-1:0] w_acc_nx;
   logic [CNT_W-1:0]        r_cnt;
   logic [CNT_W-1:0]        w_cnt_nx;
   logic signed [ACC_W-1:0] r_y;
   logic [CNT_W-1:0]        r_beats;
   logic                    r_err;
   logic                    w_load;

   logic                    w_accept;
   logic                    w_full;
   logic [CNT_W-1:0]        w_cnt_inc;
   logic signed [ACC_W-1:0] w_d;
   logic signed [ACC_W-1:0] w_sum;
   logic [CHUNK-1:0]        w_pos_bits;
   logic [CHUNK-1:0]        w_neg_bits;
   logic [ACC_W-1:0]        w_pos_cnt [0:CHUNK];
   logic [ACC_W-1:0]        w_neg_cnt [0:CHUNK];

   // Masked-out positions contribute nothing; the rest are +1 or -1.
   assign w_pos_bits = bus.in_x &  bus.in_w & bus.in_m;
   assign w_neg_bits = bus.in_x & ~bus.in_w & bus.in_m;

   // Ripple popcount as a chain of prefix sums.
   assign w_pos_cnt[0] = '0;
   assign w_neg_cnt[0] = '0;
   generate
      for (genvar gi = 0; gi < CHUNK; gi++) begin : g_pop
         assign w_pos_cnt[gi+1] = w_pos_cnt[gi] + ACC_W'(w_pos_bits[gi]);
         assign w_neg_cnt[gi+1] = w_neg_cnt[gi] + ACC_W'(w_neg_bits[gi]);
      end
   endgenerate

   assign w_d       = $signed(w_pos_cnt[CHUNK]) - $signed(w_neg_cnt[CHUNK]);
   assign w_sum     = r_acc + w_d;
   assign w_cnt_inc = r_cnt + CNT_W'(1);
   assign w_full    = (w_cnt_inc == MAX_CNT);

   // No beats taken while a result is pending or while held in reset.
   assign bus.in_ready  = (r_state != S_HOLD) && !reset;
   assign w_accept      = bus.in_valid && bus.in_ready;
   assign bus.out_valid = (r_state == S_HOLD);
   assign bus.out_y     = r_y;
   assign bus.out_beats = r_beats;
   assign bus.out_err   = r_err;

   // State, accumulator and beat counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_acc   <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nx;
         r_acc   <= w_acc_nx;
         r_cnt   <= w_cnt_nx;
      end
   end

   // Next-state logic: close the frame on in_last or when the beat limit is hit.
   always_comb begin
      w_state_nx = r_state;
      w_acc_nx   = r_acc;
      w_cnt_nx   = r_cnt;
      w_load     = 1'b0;
      case (r_state)
         S_IDLE, S_ACCUM: begin
            if (w_accept) begin
               if (bus.in_last || w_full) begin
                  w_state_nx = S_HOLD;
                  w_load     = 1'b1;
                  w_acc_nx   = '0;
                  w_cnt_nx   = '0;
               end else begin
                  w_state_nx = S_ACCUM;
                  w_acc_nx   = w_sum;
                  w_cnt_nx   = w_cnt_inc;
               end
            end
         end
         S_HOLD: begin
            if (bus.out_ready) begin
               w_state_nx = S_IDLE;
            end
         end
         default: begin
            w_state_nx = S_IDLE;
            w_acc_nx   = '0;
            w_cnt_nx   = '0;
         end
      endcase
   end

   // Result registers: loaded once per frame, held until the next frame closes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_y     <= '0;
         r_beats <= '0;
         r_err   <= 1'b0;
      end else if (w_load) begin
         r_y     <= w_sum;
         r_beats <= w_cnt_inc;
         r_err   <= w_full && !bus.in_last;
      end
   end
endmodule

// File: tb/tb_binary_mac_stream.sv
// Bench for binary_mac_stream: table of beats with expected frame results
// pushed into a scoreboard, plus hand sequences for latency, backpressure
// and asynchronous reset.
module tb_binary_mac_stream;
   localparam int CHUNK      = 8;
   localparam int MAX_CHUNKS = 8;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   binary_mac_stream_if #(.CHUNK(CHUNK), .MAX_CHUNKS(MAX_CHUNKS)) bus ();

   binary_mac_stream #(.CHUNK(CHUNK), .MAX_CHUNKS(MAX_CHUNKS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [7:0] x;
      logic [7:0] w;
      logic [7:0] m;
      logic       last;
      logic       has_exp;
      logic [7:0] y;
      logic [3:0] beats;
      logic       err;
   } vec_t;

   typedef struct {
      logic [7:0] y;
      logic [3:0] beats;
      logic       err;
   } res_t;

   vec_t vecs[$];
   res_t sb[$];
   res_t mon_e;
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic [7:0] x, input logic [7:0] w, input logic [7:0] m,
                      input logic last, input logic has_exp, input logic [7:0] y,
                      input logic [3:0] beats, input logic err);
      vec_t v;
      v.x = x; v.w = w; v.m = m; v.last = last;
      v.has_exp = has_exp; v.y = y; v.beats = beats; v.err = err;
      vecs.push_back(v);
   endtask

   task automatic push_exp(input logic [7:0] y, input logic [3:0] beats, input logic err);
      res_t r;
      r.y = y; r.beats = beats; r.err = err;
      sb.push_back(r);
   endtask

   // Drive one beat and wait (bounded) for it to be accepted.
   task automatic send_beat(input logic [7:0] x, input logic [7:0] w, input logic [7:0] m,
                            input logic last);
      int n;
      @(negedge clk);
      bus.in_x = x; bus.in_w = w; bus.in_m = m; bus.in_last = last;
      bus.in_valid = 1'b1;
      n = 0;
      while (!bus.in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         total++;
         bad++;
         $display("FAIL beat_accept: got timeout want in_ready");
         bus.in_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1 bus.in_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      check("drain", sb.size(), 0);
   endtask

   // Output monitor: each completed result handshake is compared with the scoreboard.
   always @(negedge clk) begin
      if (reset === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result: got y=%0h want none", bus.out_y);
         end else begin
            mon_e = sb.pop_front();
            $display("result y=%0d beats=%0d err=%0b", $signed(bus.out_y), bus.out_beats, bus.out_err);
            check("out_y", {24'b0, bus.out_y}, {24'b0, mon_e.y});
            check("out_beats", {28'b0, bus.out_beats}, {28'b0, mon_e.beats});
            check("out_err", {31'b0, bus.out_err}, {31'b0, mon_e.err});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      bus.in_valid = 1'b0; bus.in_x = '0; bus.in_w = '0; bus.in_m = '0;
      bus.in_last = 1'b0; bus.out_ready = 1'b1;

      // Beat table: expected frame result rides on the beat that closes the frame.
      add(8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1, 8'd8, 4'd1, 1'b0);
      for (int i = 0; i < 8; i++)
         add(8'hFF, 8'h0F, 8'hFF, i == 7, i == 7, 8'd0, 4'd8, 1'b0);
      for (int i = 0; i < 8; i++)
         add(8'hFF, 8'h00, 8'hFF, i == 7, i == 7, 8'hC0, 4'd8, 1'b0);
      add(8'hFF, 8'hFF, 8'h0F, 1'b1, 1'b1, 8'd4, 4'd1, 1'b0);
      add(8'hFF, 8'hFF, 8'h00, 1'b1, 1'b1, 8'd0, 4'd1, 1'b0);
      for (int i = 0; i < 8; i++)
         add(8'hFF, 8'hFF, 8'hFF, 1'b0, i == 7, 8'd64, 4'd8, 1'b1);
      add(8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1, 8'd8, 4'd1, 1'b0);
      add(8'hF3, 8'h3C, 8'hE7, 1'b0, 1'b0, 8'd0, 4'd0, 1'b0);
      add(8'h5A, 8'hFF, 8'hFF, 1'b1, 1'b1, 8'd1, 4'd2, 1'b0);

      // Reset state
      #12;
      check("rst_out_valid", {31'b0, bus.out_valid}, 0);
      check("rst_out_y", {24'b0, bus.out_y}, 0);
      check("rst_out_beats", {28'b0, bus.out_beats}, 0);
      check("rst_out_err", {31'b0, bus.out_err}, 0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1 check("rst_in_ready", {31'b0, bus.in_ready}, 1);

      // Latency: result visible right after the accepting edge
      push_exp(8'd8, 4'd1, 1'b0);
      send_beat(8'hFF, 8'hFF, 8'hFF, 1'b1);
      check("latency_out_valid", {31'b0, bus.out_valid}, 1);
      drain();

      // Table
      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].has_exp) push_exp(vecs[i].y, vecs[i].beats, vecs[i].err);
         send_beat(vecs[i].x, vecs[i].w, vecs[i].m, vecs[i].last);
      end
      drain();

      // Backpressure: result held, extra beats refused
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      push_exp(8'd8, 4'd1, 1'b0);
      send_beat(8'hFF, 8'hFF, 8'hFF, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.in_x = 8'hFF; bus.in_w = 8'h00; bus.in_m = 8'hFF; bus.in_last = 1'b1;
         bus.in_valid = 1'b1;
         check("bp_in_ready", {31'b0, bus.in_ready}, 0);
         check("bp_out_valid", {31'b0, bus.out_valid}, 1);
         check("bp_out_y", {24'b0, bus.out_y}, 8);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_release_out_valid", {31'b0, bus.out_valid}, 0);
      check("bp_release_in_ready", {31'b0, bus.in_ready}, 1);
      check("bp_sb_empty", sb.size(), 0);

      // Asynchronous reset mid-frame
      for (int i = 0; i < 3; i++) send_beat(8'hFF, 8'hFF, 8'hFF, 1'b0);
      @(posedge clk);
      #3 reset = 1'b1;
      #1;
      check("arst_out_valid", {31'b0, bus.out_valid}, 0);
      check("arst_out_y", {24'b0, bus.out_y}, 0);
      check("arst_out_beats", {28'b0, bus.out_beats}, 0);
      check("arst_out_err", {31'b0, bus.out_err}, 0);
      #20;
      @(negedge clk);
      reset = 1'b0;
      push_exp(8'hF8, 4'd1, 1'b0);
      send_beat(8'hFF, 8'h00, 8'hFF, 1'b1);
      drain();

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
